// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG pool: FSM encoding and port-width helpers.
package trng_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALIB   = 3'd1,
    S_COLLECT = 3'd2,
    S_WAIT    = 3'd3,
    S_FAIL    = 3'd4
  } trng_state_t;

  // Width of a select able to address n items (at least one bit)
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of an occupancy counter that must also represent "depth" itself
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trng_pool_if.sv
// Read-side bus of the TRNG pool: output gate, pop request and FIFO head view.
interface trng_pool_if
  import trng_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
);

  logic                             iEn;
  logic                             iRead;
  logic                             oReady;
  logic [WORD_W-1:0]                oRandom;
  logic [cnt_w(FIFO_DEPTH)-1:0]     oCount;

  modport master (
    output iEn,
    output iRead,
    input  oReady,
    input  oRandom,
    input  oCount
  );

  modport slave (
    input  iEn,
    input  iRead,
    output oReady,
    output oRandom,
    output oCount
  );

endinterface

// File: rtl/trng_word_fifo.sv
// First-word-fall-through word FIFO. The head word is visible without a pop;
// a push while full is accepted only when a pop frees the slot in that cycle.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORD_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  // Qualify push/pop against occupancy and expose status and the head word
  always_comb begin
    empty     = (count_r == CNT_W'(0));
    full      = (count_r == CNT_W'(DEPTH));
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    count     = count_r;
    if (empty) begin
      rdata = {WORD_W{1'b0}};
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge iClk) begin
    if (!iRst_n || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

  // Word storage; contents are only observable while occupancy is non-zero
  always_ff @(posedge iClk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/trng_pool.sv
// TRNG sampler: enables one ring-generator base, calibrates it, then collects
// MSB-first words into a FWFT FIFO in the background. A repetition-count
// health test abandons a stuck stream and raises a sticky failure flag.
module trng_pool
  import trng_pkg::*;
#(
  parameter int NUM_BASES  = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_LIMIT  = 16
) (
  input  logic                          iClk,
  input  logic                          iRst_n,
  input  logic                          iCalib,
  input  logic [31:0]                   iCalib_cycles,
  input  logic [sel_w(NUM_BASES)-1:0]   iSel_base,
  input  logic [NUM_BASES-1:0]          iSerial,
  output logic [NUM_BASES-1:0]          oEn_base,
  output logic                          oHealth_fail,
  trng_pool_if.slave                    bus
);

  localparam int SEL_W = sel_w(NUM_BASES);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int RUN_W = 6;

  trng_state_t       state_r;
  trng_state_t       state_nxt_s;
  logic [SEL_W-1:0]  sel_r;
  logic [31:0]       calib_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic              prev_bit_r;
  logic [RUN_W-1:0]  run_len_r;
  logic              fail_r;
  logic              read_d_r;

  logic              collect_s;
  logic              bit_s;
  logic [RUN_W-1:0]  run_next_s;
  logic              trip_s;
  logic [WORD_W-1:0] word_s;
  logic              word_done_s;
  logic              push_s;
  logic              pop_s;
  logic              pop_ok_s;
  logic [CNT_W:0]    fill_cnt_s;
  logic              will_fill_s;
  logic              calib_done_s;
  logic              calib_ok_s;
  logic              flush_s;
  logic [SEL_W-1:0]  sel_in_s;

  logic [WORD_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;
  logic [CNT_W-1:0]  count_s;

  // Per-cycle datapath decisions: health run, word completion, pop edge, calibration end
  always_comb begin
    collect_s = (state_r == S_COLLECT);
    bit_s     = iSerial[sel_r];
    if ((run_len_r != RUN_W'(0)) && (bit_s == prev_bit_r)) begin
      run_next_s = run_len_r + RUN_W'(1);
    end else begin
      run_next_s = RUN_W'(1);
    end
    trip_s       = collect_s && (run_next_s >= RUN_W'(REP_LIMIT));
    word_s       = {shift_r[WORD_W-2:0], bit_s};
    word_done_s  = collect_s && (bit_cnt_r == BIT_W'(WORD_W - 1));
    // A tripping bit never completes a word, even on the last bit position
    push_s       = word_done_s && !trip_s;
    pop_s        = bus.iEn && bus.iRead && !read_d_r;
    pop_ok_s     = pop_s && !empty_s;
    fill_cnt_s   = {1'b0, count_s} + (CNT_W+1)'(1) - (CNT_W+1)'(pop_ok_s);
    will_fill_s  = push_s && (fill_cnt_s == (CNT_W+1)'(FIFO_DEPTH));
    calib_done_s = ({1'b0, calib_cnt_r} + 33'd1) >= {1'b0, iCalib_cycles};
    calib_ok_s   = iCalib && ((state_r == S_IDLE) || (state_r == S_FAIL));
    flush_s      = iCalib && (state_r == S_FAIL);
    if ({1'b0, iSel_base} < (SEL_W+1)'(NUM_BASES)) begin
      sel_in_s = iSel_base;
    end else begin
      sel_in_s = {SEL_W{1'b0}};
    end
  end

  // FSM state register
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and base enable decode
  always_comb begin
    state_nxt_s = state_r;
    oEn_base    = {NUM_BASES{1'b0}};
    case (state_r)
      S_IDLE: begin
        if (iCalib) state_nxt_s = S_CALIB;
        else        state_nxt_s = S_IDLE;
      end
      S_CALIB: begin
        oEn_base[sel_r] = 1'b1;
        if (calib_done_s) state_nxt_s = S_COLLECT;
        else              state_nxt_s = S_CALIB;
      end
      S_COLLECT: begin
        oEn_base[sel_r] = 1'b1;
        if (trip_s)           state_nxt_s = S_FAIL;
        else if (will_fill_s) state_nxt_s = S_WAIT;
        else                  state_nxt_s = S_COLLECT;
      end
      S_WAIT: begin
        if (!full_s) state_nxt_s = S_COLLECT;
        else         state_nxt_s = S_WAIT;
      end
      S_FAIL: begin
        if (iCalib) state_nxt_s = S_CALIB;
        else        state_nxt_s = S_FAIL;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Base select latch and calibration cycle counter
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      sel_r       <= {SEL_W{1'b0}};
      calib_cnt_r <= 32'd0;
    end else begin
      if (calib_ok_s) begin
        sel_r <= sel_in_s;
      end
      if (state_r == S_CALIB) begin
        calib_cnt_r <= calib_cnt_r + 32'd1;
      end else begin
        calib_cnt_r <= 32'd0;
      end
    end
  end

  // Shifter, bit counter and repetition-run tracker; run history restarts on each COLLECT entry
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      shift_r    <= {WORD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      prev_bit_r <= 1'b0;
      run_len_r  <= {RUN_W{1'b0}};
    end else if (collect_s && !trip_s) begin
      shift_r    <= word_s;
      prev_bit_r <= bit_s;
      run_len_r  <= run_next_s;
      if (word_done_s) begin
        bit_cnt_r <= {BIT_W{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end
    end else begin
      bit_cnt_r  <= {BIT_W{1'b0}};
      prev_bit_r <= 1'b0;
      run_len_r  <= {RUN_W{1'b0}};
    end
  end

  // Sticky health flag and read-request history for edge detection
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      fail_r   <= 1'b0;
      read_d_r <= 1'b0;
    end else begin
      read_d_r <= bus.iRead;
      if (flush_s) begin
        fail_r <= 1'b0;
      end else if (trip_s) begin
        fail_r <= 1'b1;
      end
    end
  end

  trng_word_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .flush  (flush_s),
    .push   (push_s),
    .pop    (pop_s),
    .wdata  (word_s),
    .rdata  (head_s),
    .full   (full_s),
    .empty  (empty_s),
    .count  (count_s)
  );

  // Output gate: iEn masks the read-side view only; FSM and FIFO keep running
  always_comb begin
    oHealth_fail = fail_r;
    if (bus.iEn) begin
      bus.oReady  = !empty_s;
      bus.oRandom = head_s;
      bus.oCount  = count_s;
    end else begin
      bus.oReady  = 1'b0;
      bus.oRandom = {WORD_W{1'b0}};
      bus.oCount  = {CNT_W{1'b0}};
    end
  end

endmodule
